// File: rtl/gemac_pkg.sv
// gemac_pkg: shared MAC-control constants and the PAUSE transmitter state type.
package gemac_pkg;

    localparam logic [47:0] PAUSE_DA           = 48'h0180C2000001;
    localparam logic [15:0] MAC_CTRL_ETHERTYPE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE       = 16'h0001;
    localparam int          PAUSE_HDR_BYTES    = 18;

    typedef enum logic [1:0] {IDLE, SEND, GAP} pause_tx_state_t;

endpackage

// File: rtl/pause_byte_sel.sv
// pause_byte_sel: combinational PAUSE frame byte mux indexed by the byte counter.
module pause_byte_sel
    import gemac_pkg::*;
#(
    parameter int CW            = 6,
    parameter bit SRC_FROM_PORT = 1'b1
) (
    input  logic [CW-1:0] cnt_i,
    input  logic [47:0]   mac_addr_i,
    input  logic [15:0]   frame_time_i,
    output logic [7:0]    byte_o
);

    localparam int HDR_W = 8 * PAUSE_HDR_BYTES;

    logic [47:0]      sa;
    logic [HDR_W-1:0] hdr;
    logic [HDR_W-1:0] shifted;

    assign sa  = SRC_FROM_PORT ? mac_addr_i : 48'h0;
    assign hdr = {PAUSE_DA, sa, MAC_CTRL_ETHERTYPE, PAUSE_OPCODE, frame_time_i};

    // Indices past the header shift every header bit out, which yields the zero pad.
    assign shifted = hdr << {cnt_i, 3'b000};
    assign byte_o  = shifted[HDR_W-1 -: 8];

endmodule

// File: rtl/pause_frame_tx.sv
// pause_frame_tx: 802.3x PAUSE frame byte-stream generator with request coalescing.
// Define PAUSE_FRAME_TX_STATS_EN to add the sent/coalesced statistics outputs.
module pause_frame_tx
    import gemac_pkg::*;
#(
    parameter int PAD_BYTES     = 42,
    parameter bit SRC_FROM_PORT = 1'b1
) (
    input  logic        tx_clk,
    input  logic        tx_reset,
    input  logic [47:0] mac_addr,
    input  logic        pause_req,
    input  logic [15:0] pause_time_req,
    output logic [7:0]  pause_tx_data,
    output logic        pause_tx_valid,
    output logic        pause_tx_last,
    input  logic        pause_tx_ready,
`ifdef PAUSE_FRAME_TX_STATS_EN
    output logic [15:0] pause_frames_sent,
    output logic [15:0] pause_req_coalesced,
`endif
    output logic        pause_busy
);

    localparam int            FRAME_BYTES = PAUSE_HDR_BYTES + PAD_BYTES;
    localparam int            CW          = $clog2(FRAME_BYTES);
    localparam logic [CW-1:0] LAST_IDX    = CW'(FRAME_BYTES - 1);

    pause_tx_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic [15:0]     pend_time_q, pend_time_d;
    logic [15:0]     frame_time_q, frame_time_d;
    logic [7:0]      sel_byte;
    logic            accept;
    logic            last;

    pause_byte_sel #(
        .CW           (CW),
        .SRC_FROM_PORT(SRC_FROM_PORT)
    ) u_byte_sel (
        .cnt_i       (cnt_q),
        .mac_addr_i  (mac_addr),
        .frame_time_i(frame_time_q),
        .byte_o      (sel_byte)
    );

    assign pause_tx_valid = (state_q == SEND);
    assign last           = (cnt_q == LAST_IDX);
    assign pause_tx_last  = pause_tx_valid & last;
    assign pause_tx_data  = pause_tx_valid ? sel_byte : 8'h00;
    assign accept         = pause_tx_valid & pause_tx_ready;
    assign pause_busy     = (state_q != IDLE) | pending_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | pause_req;
        pend_time_d  = pause_req ? pause_time_req : pend_time_q;
        frame_time_d = frame_time_q;
        case (state_q)
            IDLE: begin
                // A strobe on the launch edge wins; it only stays pending if one already was.
                if (pending_q || pause_req) begin
                    state_d      = SEND;
                    cnt_d        = '0;
                    frame_time_d = pause_req ? pause_time_req : pend_time_q;
                    pending_d    = pending_q & pause_req;
                end
            end
            SEND: begin
                if (accept) begin
                    state_d = last ? GAP : SEND;
                    cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            pend_time_q  <= 16'h0;
            frame_time_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            pend_time_q  <= pend_time_d;
            frame_time_q <= frame_time_d;
        end
    end

`ifdef PAUSE_FRAME_TX_STATS_EN
    logic [15:0] sent_q, sent_d;
    logic [15:0] coal_q, coal_d;

    always_comb begin
        sent_d = (accept && last && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
        coal_d = (pause_req && pending_q && coal_q != 16'hFFFF) ? coal_q + 16'd1 : coal_q;
    end

    always_ff @(posedge tx_clk or posedge tx_reset) begin
        if (tx_reset) begin
            sent_q <= 16'h0;
            coal_q <= 16'h0;
        end else begin
            sent_q <= sent_d;
            coal_q <= coal_d;
        end
    end

    assign pause_frames_sent   = sent_q;
    assign pause_req_coalesced = coal_q;
`endif

endmodule

// File: tb/tb_pause_frame_tx.sv
// tb_pause_frame_tx: self-checking bench for pause_frame_tx against a whole-frame reference model.
// Statistics checks are compiled in when PAUSE_FRAME_TX_STATS_EN is defined.
module tb_pause_frame_tx;

    localparam int N = 60;

    logic        tx_clk;
    logic        tx_reset;
    logic [47:0] mac_addr;
    logic        pause_req;
    logic [15:0] pause_time_req;
    logic [7:0]  pause_tx_data;
    logic        pause_tx_valid;
    logic        pause_tx_last;
    logic        pause_tx_ready;
    logic        pause_busy;
`ifdef PAUSE_FRAME_TX_STATS_EN
    logic [15:0] pause_frames_sent;
    logic [15:0] pause_req_coalesced;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8*N-1:0] rx_frame;
    int             rx_wait;
    bit             rx_to, rx_unstable, rx_last_err, rx_aborted;
    logic [2:0]     rx_ab_flags;
    logic [7:0]     rx_ab_data;

    pause_frame_tx dut (
        .tx_clk             (tx_clk),
        .tx_reset           (tx_reset),
        .mac_addr           (mac_addr),
        .pause_req          (pause_req),
        .pause_time_req     (pause_time_req),
        .pause_tx_data      (pause_tx_data),
        .pause_tx_valid     (pause_tx_valid),
        .pause_tx_last      (pause_tx_last),
        .pause_tx_ready     (pause_tx_ready),
`ifdef PAUSE_FRAME_TX_STATS_EN
        .pause_frames_sent  (pause_frames_sent),
        .pause_req_coalesced(pause_req_coalesced),
`endif
        .pause_busy         (pause_busy)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: the frame as the standard defines it, byte 0 in the top bits.
    function automatic logic [8*N-1:0] model_frame(input logic [47:0] mac, input logic [15:0] t);
        return {48'h0180C2000001, mac, 16'h8808, 16'h0001, t, {(8*(N-18)){1'b0}}};
    endfunction

    // Sink one frame with a random-ready pattern; optionally strobe requests
    // (s_at >= 0: at byte s_at; s_at < 0: at idle cycle -s_at) or reset at byte abort_at.
    task automatic recv(input int pct, input int s_at, input int n_s, input logic [47:0] s_vals,
                        input int abort_at, input int wait_max);
        int         idx = 0;
        int         si = 0;
        bit         held = 0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        rx_frame = '0;
        rx_wait = 0;
        rx_to = 0;
        rx_unstable = 0;
        rx_last_err = 0;
        rx_aborted = 0;
        while (idx < N) begin
            @(negedge tx_clk);
            pause_req = 1'b0;
            if (si > 0 && si < n_s) begin
                pause_req = 1'b1;
                pause_time_req = s_vals[16*si +: 16];
                si++;
            end else if (si == 0 && n_s > 0 &&
                         (s_at < 0 ? (!pause_tx_valid && rx_wait == -s_at) : (pause_tx_valid && idx == s_at))) begin
                pause_req = 1'b1;
                pause_time_req = s_vals[15:0];
                si = 1;
            end
            if (held && (!pause_tx_valid || pause_tx_data !== pd || pause_tx_last !== pl)) rx_unstable = 1;
            if (!pause_tx_valid) begin
                if (idx > 0) rx_unstable = 1;
                if (rx_wait >= wait_max) begin
                    rx_to = 1;
                    return;
                end
                rx_wait++;
                held = 0;
                continue;
            end
            if (idx == abort_at) begin
                tx_reset = 1'b1;
                #1;
                rx_ab_flags = {pause_tx_valid, pause_tx_last, pause_busy};
                rx_ab_data = pause_tx_data;
                rx_aborted = 1;
                return;
            end
            if (pause_tx_last !== (idx == N - 1)) rx_last_err = 1;
            pause_tx_ready = int'($urandom_range(99)) < pct;
            if (pause_tx_ready) begin
                rx_frame[8*(N-1-idx) +: 8] = pause_tx_data;
                idx++;
                held = 0;
            end else begin
                held = 1;
                pd = pause_tx_data;
                pl = pause_tx_last;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge tx_clk);
        tx_reset = 1'b1;
        pause_req = 1'b0;
        pause_tx_ready = 1'b0;
        @(negedge tx_clk);
        tx_reset = 1'b0;
    endtask

    task automatic test_reset();
        tx_reset = 1'b1;
        repeat (2) @(negedge tx_clk);
        n_cmp++;
        if ({pause_tx_valid, pause_tx_last, pause_busy, pause_tx_data} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b l=%b b=%b d=%h exp all zero",
                     pause_tx_valid, pause_tx_last, pause_busy, pause_tx_data);
        end
`ifdef PAUSE_FRAME_TX_STATS_EN
        n_cmp++;
        if (pause_frames_sent !== 16'd0 || pause_req_coalesced !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stats got sent=%0d coal=%0d exp 0/0", pause_frames_sent, pause_req_coalesced);
        end
`endif
        @(negedge tx_clk);
        tx_reset = 1'b0;
    endtask

    task automatic test_single();
        reset_dut();
        pause_time_req = 16'h1234;
        pause_req = 1'b1;
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (rx_to || rx_wait != 0) begin
            n_fail++;
            $display("FAIL single_latency got wait=%0d to=%0b exp wait=0", rx_wait, rx_to);
        end
        n_cmp++;
        if (rx_frame !== model_frame(mac_addr, 16'h1234)) begin
            n_fail++;
            $display("FAIL single_frame got %h exp %h", rx_frame, model_frame(mac_addr, 16'h1234));
        end
        n_cmp++;
        if (rx_last_err) begin
            n_fail++;
            $display("FAIL single_last got misplaced last exp last only on byte %0d", N - 1);
        end
        @(negedge tx_clk);
        n_cmp++;
        if (pause_tx_valid !== 1'b0 || pause_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap got v=%b b=%b exp v=0 b=1", pause_tx_valid, pause_busy);
        end
        @(negedge tx_clk);
        n_cmp++;
        if (pause_tx_valid !== 1'b0 || pause_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got v=%b b=%b exp v=0 b=0", pause_tx_valid, pause_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] t;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            t = (i == 0) ? 16'h1234 : 16'($urandom);
            @(negedge tx_clk);
            pause_time_req = t;
            pause_req = 1'b1;
            recv(50, 0, 0, '0, -1, 20);
            n_cmp++;
            if (rx_to || rx_frame !== model_frame(mac_addr, t)) begin
                n_fail++;
                $display("FAIL bp_frame%0d got %h exp %h", i, rx_frame, model_frame(mac_addr, t));
            end
            n_cmp++;
            if (rx_unstable || rx_last_err) begin
                n_fail++;
                $display("FAIL bp_hold%0d got unstable=%0b last_err=%0b exp 0/0", i, rx_unstable, rx_last_err);
            end
        end
    endtask

    task automatic test_coalesce();
        reset_dut();
        pause_time_req = 16'h0100;
        pause_req = 1'b1;
        recv(100, 20, 2, {16'h0000, 16'h0300, 16'h0200}, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, 16'h0100)) begin
            n_fail++;
            $display("FAIL coal_first got %h exp %h", rx_frame, model_frame(mac_addr, 16'h0100));
        end
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, 16'h0300)) begin
            n_fail++;
            $display("FAIL coal_second got %h exp %h", rx_frame, model_frame(mac_addr, 16'h0300));
        end
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (!rx_to || pause_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coal_extra got frame=%0b busy=%b exp no frame, busy=0", !rx_to, pause_busy);
        end
`ifdef PAUSE_FRAME_TX_STATS_EN
        n_cmp++;
        if (pause_frames_sent !== 16'd2 || pause_req_coalesced !== 16'd1) begin
            n_fail++;
            $display("FAIL coal_stats got sent=%0d coal=%0d exp 2/1", pause_frames_sent, pause_req_coalesced);
        end
`endif
    endtask

    task automatic test_edge_strobe();
        reset_dut();
        pause_time_req = 16'h5555;
        pause_req = 1'b1;
        recv(100, 25, 1, {32'h0, 16'h7777}, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, 16'h5555)) begin
            n_fail++;
            $display("FAIL edge_first got %h exp %h", rx_frame, model_frame(mac_addr, 16'h5555));
        end
        recv(100, -1, 1, {32'h0, 16'hAAAA}, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, 16'hAAAA)) begin
            n_fail++;
            $display("FAIL edge_new_wins got %h exp %h", rx_frame, model_frame(mac_addr, 16'hAAAA));
        end
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, 16'hAAAA)) begin
            n_fail++;
            $display("FAIL edge_still_pending got %h exp %h", rx_frame, model_frame(mac_addr, 16'hAAAA));
        end
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (!rx_to) begin
            n_fail++;
            $display("FAIL edge_extra got an extra frame exp none");
        end
`ifdef PAUSE_FRAME_TX_STATS_EN
        n_cmp++;
        if (pause_frames_sent !== 16'd3 || pause_req_coalesced !== 16'd1) begin
            n_fail++;
            $display("FAIL edge_stats got sent=%0d coal=%0d exp 3/1", pause_frames_sent, pause_req_coalesced);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [15:0] t;
        reset_dut();
        pause_time_req = 16'($urandom);
        pause_req = 1'b1;
        recv(100, 10, 1, {32'h0, 16'h4321}, 30, 100);
        n_cmp++;
        if (!rx_aborted || rx_ab_flags !== 3'b000 || rx_ab_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid got aborted=%0b vlb=%b d=%h exp 1/000/00", rx_aborted, rx_ab_flags, rx_ab_data);
        end
        @(negedge tx_clk);
        tx_reset = 1'b0;
        recv(100, 0, 0, '0, -1, 30);
        n_cmp++;
        if (!rx_to || pause_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet got frame=%0b busy=%b exp no frame, busy=0", !rx_to, pause_busy);
        end
        t = 16'($urandom);
        @(negedge tx_clk);
        pause_time_req = t;
        pause_req = 1'b1;
        recv(100, 0, 0, '0, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(mac_addr, t)) begin
            n_fail++;
            $display("FAIL rst_resume got %h exp %h", rx_frame, model_frame(mac_addr, t));
        end
    endtask

    task automatic test_xon();
        logic [47:0] saved;
        saved = mac_addr;
        reset_dut();
        mac_addr = 48'h021122334455;
        pause_time_req = 16'h0000;
        pause_req = 1'b1;
        recv(70, 0, 0, '0, -1, 20);
        n_cmp++;
        if (rx_to || rx_frame !== model_frame(48'h021122334455, 16'h0000)) begin
            n_fail++;
            $display("FAIL xon_frame got %h exp %h", rx_frame, model_frame(48'h021122334455, 16'h0000));
        end
        mac_addr = saved;
    endtask

    task automatic test_random();
        bit          pend = 0;
        logic [15:0] exp_t = '0;
        logic [47:0] vals;
        int          n_s, at, pct;
        int          exp_sent = 0;
        int          exp_coal = 0;
        reset_dut();
        for (int it = 0; it < 8; it++) begin
            pct  = int'($urandom_range(30, 100));
            n_s  = int'($urandom_range(0, 3));
            at   = int'($urandom_range(0, 55));
            vals = {16'($urandom), $urandom};
            if (!pend) begin
                @(negedge tx_clk);
                mac_addr = {16'($urandom), $urandom};
                exp_t = 16'($urandom);
                pause_time_req = exp_t;
                pause_req = 1'b1;
            end
            recv(pct, at, n_s, vals, -1, 40);
            n_cmp++;
            if (rx_to || rx_unstable || rx_last_err || rx_frame !== model_frame(mac_addr, exp_t)) begin
                n_fail++;
                $display("FAIL rand_frame%0d got %h (to=%0b unst=%0b last=%0b) exp %h",
                         it, rx_frame, rx_to, rx_unstable, rx_last_err, model_frame(mac_addr, exp_t));
            end
            exp_sent++;
            // Only the newest strobe of a burst survives; every one after the first coalesces.
            pend = (n_s > 0);
            if (n_s > 0) begin
                exp_t = vals[16*(n_s-1) +: 16];
                exp_coal += n_s - 1;
            end
        end
        if (pend) begin
            recv(100, 0, 0, '0, -1, 40);
            n_cmp++;
            if (rx_to || rx_frame !== model_frame(mac_addr, exp_t)) begin
                n_fail++;
                $display("FAIL rand_tail got %h exp %h", rx_frame, model_frame(mac_addr, exp_t));
            end
            exp_sent++;
        end
`ifdef PAUSE_FRAME_TX_STATS_EN
        @(negedge tx_clk);
        n_cmp++;
        if (int'(pause_frames_sent) != exp_sent || int'(pause_req_coalesced) != exp_coal) begin
            n_fail++;
            $display("FAIL rand_stats got sent=%0d coal=%0d exp %0d/%0d",
                     pause_frames_sent, pause_req_coalesced, exp_sent, exp_coal);
        end
`else
        if (exp_sent < 0 || exp_coal < 0) $display("rand counters negative");
`endif
    endtask

    initial begin
        tx_reset = 1'b1;
        pause_req = 1'b0;
        pause_time_req = 16'h0;
        pause_tx_ready = 1'b0;
        mac_addr = 48'h00A0C9112233;
        test_reset();
        test_single();
        test_backpressure();
        test_coalesce();
        test_edge_strobe();
        test_reset_mid();
        test_xon();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
